// File: rtl/hbmc_bus_sync_filter_pkg.sv
// Package wrapping the shared sync/filter helpers for import by the slice.
package hbmc_bus_sync_filter_pkg;
`include "hbmc_sync_defs.vh"
endpackage

// File: rtl/hbmc_bus_sync_filter_glitch.sv
// One channel of glitch filter: persistence counter, filtered level, edge pulses.
// Optional sticky event flag when HBMC_SYNC_FILTER_STICKY_EN is defined.
module hbmc_glitch_filter
  import hbmc_bus_sync_filter_pkg::*;
#(
  parameter int   C_FILTER_CYCLES = 8,
  parameter logic C_RESET_LEVEL   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic s_i,
`ifdef HBMC_SYNC_FILTER_STICKY_EN
  input  logic clr_i,
  output logic evt_o,
`endif
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int CW = hbmc_cnt_width(C_FILTER_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(C_FILTER_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          q_q, q_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;

  always_comb begin
    cnt_d  = cnt_q;
    q_d    = q_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (s_i == q_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      q_d    = s_i;
      cnt_d  = '0;
      rise_d = s_i;
      fall_d = ~s_i;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      q_q    <= C_RESET_LEVEL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      q_q    <= q_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign q_o    = q_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

`ifdef HBMC_SYNC_FILTER_STICKY_EN
  logic evt_q, evt_d;

  // A pulse generated on this edge beats a simultaneous clear.
  always_comb begin
    evt_d = evt_q;
    if (rise_d || fall_d) evt_d = 1'b1;
    else if (clr_i)       evt_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) evt_q <= 1'b0;
    else     evt_q <= evt_d;
  end

  assign evt_o = evt_q;
`endif

endmodule

// File: rtl/hbmc_sync_defs.vh
// Shared helpers for the synchronizer/filter slice: counter sizing and sync-flop attribute strings.
`ifndef HBMC_SYNC_DEFS_VH
`define HBMC_SYNC_DEFS_VH

`define HBMC_SYNC_ASYNC_REG "TRUE"
`define HBMC_SYNC_SHREG_EXTRACT "no"

function automatic int hbmc_clog2(input int value);
  int r;
  r = 0;
  while ((1 << r) < value) r++;
  return r;
endfunction

// A 1-cycle filter still needs a (constant zero) counter bit.
function automatic int hbmc_cnt_width(input int cycles);
  return (hbmc_clog2(cycles) < 1) ? 1 : hbmc_clog2(cycles);
endfunction

`endif

// File: rtl/hbmc_bus_sync_filter.sv
// Multi-channel async-input synchronizer with per-channel glitch filter and edge pulses.
// Define HBMC_SYNC_FILTER_STICKY_EN to add sticky event flags (clr/evt ports).
module hbmc_bus_sync_filter
  import hbmc_bus_sync_filter_pkg::*;
#(
  parameter int                    C_CHANNELS      = 4,
  parameter int                    C_SYNC_STAGES   = 3,
  parameter logic [C_CHANNELS-1:0] C_RESET_STATE   = {C_CHANNELS{1'b0}},
  parameter int                    C_FILTER_CYCLES = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [C_CHANNELS-1:0] d,
`ifdef HBMC_SYNC_FILTER_STICKY_EN
  input  logic [C_CHANNELS-1:0] clr,
  output logic [C_CHANNELS-1:0] evt,
`endif
  output logic [C_CHANNELS-1:0] q,
  output logic [C_CHANNELS-1:0] rise,
  output logic [C_CHANNELS-1:0] fall
);

  logic [C_CHANNELS-1:0] sync_s;

  generate
    for (genvar gi = 0; gi < C_CHANNELS; gi++) begin : g_ch
      // Pure flop-to-flop chain so placement keeps the stages adjacent.
      (* ASYNC_REG = "TRUE", shreg_extract = "no" *)
      logic [C_SYNC_STAGES-1:0] sync_q;

      always_ff @(posedge clk) begin
        if (rst) sync_q <= {C_SYNC_STAGES{C_RESET_STATE[gi]}};
        else     sync_q <= {sync_q[C_SYNC_STAGES-2:0], d[gi]};
      end

      assign sync_s[gi] = sync_q[C_SYNC_STAGES-1];

      hbmc_glitch_filter #(
        .C_FILTER_CYCLES (C_FILTER_CYCLES),
        .C_RESET_LEVEL   (C_RESET_STATE[gi])
      ) u_filter (
        .clk    (clk),
        .rst    (rst),
        .s_i    (sync_s[gi]),
`ifdef HBMC_SYNC_FILTER_STICKY_EN
        .clr_i  (clr[gi]),
        .evt_o  (evt[gi]),
`endif
        .q_o    (q[gi]),
        .rise_o (rise[gi]),
        .fall_o (fall[gi])
      );
    end
  endgenerate

endmodule
